// File: rtl/risc_pkg.sv
// Shared encodings for the RISC pipeline sequencer: operand-bypass selects,
// the MD value that marks a load, and the PC the core starts from.
package risc_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_EX = 2'b01,
        FWD_WB = 2'b10
    } fwd_sel_e;

    localparam logic MD_LOAD  = 1'b1;
    localparam int   RESET_PC = 0;

endpackage

// File: rtl/risc_pipe_ctrl_if.sv
// Bundle between the pipeline sequencer (master) and the datapath/imem side (slave).
interface risc_pipe_ctrl_if
    import risc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 14,
    parameter int REG_AW = 5
);
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ready;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] ir;
    logic [PC_W-1:0]   pc_1;
    logic [PC_W-1:0]   pc_2;
    logic [REG_AW-1:0] dec_aa;
    logic [REG_AW-1:0] dec_ba;
    logic              dec_use_a;
    logic              dec_use_b;
    logic              dec_rw;
    logic [REG_AW-1:0] dec_da;
    logic              dec_load;
    logic              br_taken;
    logic [PC_W-1:0]   br_target;
    logic              stall;
    fwd_sel_e          fwd_a;
    fwd_sel_e          fwd_b;
    logic              ex_valid;
    logic              wb_valid;
    logic              ex_rw;
    logic              wb_rw;
    logic [REG_AW-1:0] wb_da;

    modport master (
        output imem_addr, ir, pc_1, pc_2, stall, fwd_a, fwd_b,
               ex_valid, wb_valid, ex_rw, wb_rw, wb_da,
        input  imem_ready, imem_rdata, dec_aa, dec_ba, dec_use_a, dec_use_b,
               dec_rw, dec_da, dec_load, br_taken, br_target
    );

    modport slave (
        input  imem_addr, ir, pc_1, pc_2, stall, fwd_a, fwd_b,
               ex_valid, wb_valid, ex_rw, wb_rw, wb_da,
        output imem_ready, imem_rdata, dec_aa, dec_ba, dec_use_a, dec_use_b,
               dec_rw, dec_da, dec_load, br_taken, br_target
    );

endinterface

// File: rtl/risc_hazard_unit.sv
// Combinational RAW detection for the two DOF sources against the EX and WB
// producers; yields bypass selects and the stall request.
module risc_hazard_unit
    import risc_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int FORWARD = 1
) (
    input  logic              dof_valid,
    input  logic              use_a,
    input  logic [REG_AW-1:0] aa,
    input  logic              use_b,
    input  logic [REG_AW-1:0] ba,
    input  logic              ex_rw,
    input  logic [REG_AW-1:0] ex_da,
    input  logic              ex_load,
    input  logic              wb_rw,
    input  logic [REG_AW-1:0] wb_da,
    output fwd_sel_e          fwd_a,
    output fwd_sel_e          fwd_b,
    output logic              stall
);
    localparam bit FWD_EN = (FORWARD != 0);

    logic [1:0]        src_use;
    logic [REG_AW-1:0] src_addr [2];
    logic [1:0]        ex_hit;
    logic [1:0]        wb_hit;
    fwd_sel_e          src_fwd  [2];

    assign src_use     = {use_b, use_a};
    assign src_addr[0] = aa;
    assign src_addr[1] = ba;

    // EX is checked first: it holds the younger write to the same register.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign ex_hit[gi] = dof_valid && src_use[gi] && (src_addr[gi] != '0)
                            && ex_rw && (src_addr[gi] == ex_da);
        assign wb_hit[gi] = dof_valid && src_use[gi] && (src_addr[gi] != '0)
                            && wb_rw && (src_addr[gi] == wb_da);
        assign src_fwd[gi] = (FWD_EN && ex_hit[gi] && !ex_load) ? FWD_EX :
                             (FWD_EN && wb_hit[gi])             ? FWD_WB : FWD_RF;
    end

    assign fwd_a = src_fwd[0];
    assign fwd_b = src_fwd[1];
    assign stall = FWD_EN ? ((|ex_hit) && ex_load) : ((|ex_hit) || (|wb_hit));

endmodule

// File: rtl/risc_pipe_ctrl.sv
// Pipeline sequencer: owns PC and the IF/DOF/EX/WB valid and destination
// registers; resolves hazards via risc_hazard_unit and redirects on branches.
module risc_pipe_ctrl
    import risc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 14,
    parameter int REG_AW  = 5,
    parameter int FORWARD = 1
) (
    input logic             clk,
    input logic             reset,
    risc_pipe_ctrl_if.master bus
);
    logic [PC_W-1:0]   pc_reg, pc_1_reg, pc_2_reg, pc_inc;
    logic [DATA_W-1:0] ir_reg;
    logic              dof_valid_reg;
    logic              ex_valid_reg, ex_rw_reg, ex_load_reg;
    logic [REG_AW-1:0] ex_da_reg;
    logic              wb_valid_reg, wb_rw_reg;
    logic [REG_AW-1:0] wb_da_reg;
    logic              haz_stall, redirect;
    fwd_sel_e          fwd_a, fwd_b;

    risc_hazard_unit #(.REG_AW(REG_AW), .FORWARD(FORWARD)) u_hazard (
        .dof_valid (dof_valid_reg),
        .use_a     (bus.dec_use_a),
        .aa        (bus.dec_aa),
        .use_b     (bus.dec_use_b),
        .ba        (bus.dec_ba),
        .ex_rw     (ex_rw_reg),
        .ex_da     (ex_da_reg),
        .ex_load   (ex_load_reg),
        .wb_rw     (wb_rw_reg),
        .wb_da     (wb_da_reg),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .stall     (haz_stall)
    );

    assign pc_inc   = pc_reg + PC_W'(1);
    assign redirect = bus.br_taken && ex_valid_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg        <= PC_W'(RESET_PC);
            ir_reg        <= '0;
            pc_1_reg      <= '0;
            pc_2_reg      <= '0;
            dof_valid_reg <= 1'b0;
            ex_valid_reg  <= 1'b0;
            ex_rw_reg     <= 1'b0;
            ex_da_reg     <= '0;
            ex_load_reg   <= 1'b0;
            wb_valid_reg  <= 1'b0;
            wb_rw_reg     <= 1'b0;
            wb_da_reg     <= '0;
        end else begin
            wb_valid_reg <= ex_valid_reg;
            wb_rw_reg    <= ex_valid_reg && ex_rw_reg;
            wb_da_reg    <= ex_da_reg;
            // A taken branch squashes DOF and EX and wins over stall and fetch.
            if (redirect) begin
                pc_reg        <= bus.br_target;
                dof_valid_reg <= 1'b0;
                ex_valid_reg  <= 1'b0;
                ex_rw_reg     <= 1'b0;
                ex_load_reg   <= 1'b0;
            end else if (haz_stall) begin
                ex_valid_reg <= 1'b0;
                ex_rw_reg    <= 1'b0;
                ex_load_reg  <= 1'b0;
            end else begin
                ex_valid_reg <= dof_valid_reg;
                ex_rw_reg    <= dof_valid_reg && bus.dec_rw;
                ex_da_reg    <= bus.dec_da;
                ex_load_reg  <= dof_valid_reg && (bus.dec_load == MD_LOAD);
                pc_2_reg     <= pc_1_reg;
                if (bus.imem_ready) begin
                    ir_reg        <= bus.imem_rdata;
                    pc_1_reg      <= pc_inc;
                    pc_reg        <= pc_inc;
                    dof_valid_reg <= 1'b1;
                end else begin
                    dof_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign bus.imem_addr = pc_reg;
    assign bus.ir        = ir_reg;
    assign bus.pc_1      = pc_1_reg;
    assign bus.pc_2      = pc_2_reg;
    assign bus.stall     = haz_stall && !redirect;
    assign bus.fwd_a     = fwd_a;
    assign bus.fwd_b     = fwd_b;
    assign bus.ex_valid  = ex_valid_reg;
    assign bus.wb_valid  = wb_valid_reg;
    assign bus.ex_rw     = ex_rw_reg;
    assign bus.wb_rw     = wb_rw_reg;
    assign bus.wb_da     = wb_da_reg;

endmodule

// File: tb/tb_risc_pipe_ctrl.sv
// Directed bench: a FORWARD=1 and a FORWARD=0 sequencer run the same small
// programs; the bench decodes its own instruction format to drive dec_*/br_*.
module tb_risc_pipe_ctrl;
    import risc_pkg::*;

    logic        clk;
    logic        reset;
    logic        imem_ready;
    logic [31:0] prog [0:16383];
    logic [31:0] exw_f, exw_s;
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          edge_n       = 0;

    risc_pipe_ctrl_if #(.DATA_W(32), .PC_W(14), .REG_AW(5)) bf ();
    risc_pipe_ctrl_if #(.DATA_W(32), .PC_W(14), .REG_AW(5)) bs ();

    risc_pipe_ctrl #(.DATA_W(32), .PC_W(14), .REG_AW(5), .FORWARD(1)) u_fwd (
        .clk(clk), .reset(reset), .bus(bf));
    risc_pipe_ctrl #(.DATA_W(32), .PC_W(14), .REG_AW(5), .FORWARD(0)) u_stl (
        .clk(clk), .reset(reset), .bus(bs));

    always #5 clk = ~clk;

    // Word layout: [31] br [30] load [29] rw [28] use_a [27] use_b
    // [26:22] da [21:17] aa [16:12] ba; a branch target sits in [13:0].
    always_comb begin
        bf.imem_ready = imem_ready;
        bf.imem_rdata = prog[bf.imem_addr];
        bf.dec_load   = bf.ir[30];
        bf.dec_rw     = bf.ir[29];
        bf.dec_use_a  = bf.ir[28];
        bf.dec_use_b  = bf.ir[27];
        bf.dec_da     = bf.ir[26:22];
        bf.dec_aa     = bf.ir[21:17];
        bf.dec_ba     = bf.ir[16:12];
        exw_f         = prog[bf.pc_2 - 14'd1];
        bf.br_taken   = exw_f[31];
        bf.br_target  = exw_f[13:0];
    end

    always_comb begin
        bs.imem_ready = imem_ready;
        bs.imem_rdata = prog[bs.imem_addr];
        bs.dec_load   = bs.ir[30];
        bs.dec_rw     = bs.ir[29];
        bs.dec_use_a  = bs.ir[28];
        bs.dec_use_b  = bs.ir[27];
        bs.dec_da     = bs.ir[26:22];
        bs.dec_aa     = bs.ir[21:17];
        bs.dec_ba     = bs.ir[16:12];
        exw_s         = prog[bs.pc_2 - 14'd1];
        bs.br_taken   = exw_s[31];
        bs.br_target  = exw_s[13:0];
    end

    function automatic logic [31:0] op(input logic ld, input logic rw, input logic ua,
                                       input logic ub, input logic [4:0] da,
                                       input logic [4:0] aa, input logic [4:0] ba);
        return {1'b0, ld, rw, ua, ub, da, aa, ba, 12'h000};
    endfunction

    function automatic logic [31:0] br_op(input logic [13:0] target, input logic ld,
                                          input logic rw, input logic [4:0] da);
        logic [31:0] w;
        w       = op(ld, rw, 1'b0, 1'b0, da, 5'd0, 5'd0);
        w[31]   = 1'b1;
        w[13:0] = target;
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] %s ok (%0h)", tag, got);
        end
    endtask

    // Hold reset and load a program of harmless filler words (no rw/use/br).
    task automatic begin_prog();
        @(negedge clk);
        reset      = 1'b1;
        imem_ready = 1'b1;
        for (int k = 0; k < 16384; k++) prog[k] = 32'h0400_0000 | 32'(k);
    endtask

    task automatic go();
        @(negedge clk);
        reset  = 1'b0;
        edge_n = 0;
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    initial begin
        clk        = 1'b0;
        reset      = 1'b1;
        imem_ready = 1'b1;
        for (int k = 0; k < 16384; k++) prog[k] = 32'h0400_0000 | 32'(k);
        #12;
        check("rst_addr",  32'(bf.imem_addr), 32'd0);
        check("rst_ir",    bf.ir, 32'd0);
        check("rst_pc1",   32'(bf.pc_1), 32'd0);
        check("rst_pc2",   32'(bf.pc_2), 32'd0);
        check("rst_valid", {bf.ex_valid, bf.wb_valid, bf.ex_rw, bf.wb_rw}, 32'd0);
        check("rst_wbda",  32'(bf.wb_da), 32'd0);
        check("rst_ctl",   {bf.stall, bf.fwd_a, bf.fwd_b}, 32'd0);

        // Scenario 1: mid-run asynchronous reset at PC 7, then restart from 0.
        go();
        run_to(7);
        check("s1_addr7", 32'(bf.imem_addr), 32'd7);
        check("s1_ir7",   bf.ir, prog[6]);
        #2 reset = 1'b1;
        #1;
        check("s1_arst_addr",  32'(bf.imem_addr), 32'd0);
        check("s1_arst_valid", {bf.ex_valid, bf.wb_valid}, 32'd0);
        check("s1_arst_ir",    bf.ir, 32'd0);
        go();
        run_to(1);
        check("s1_f0", bf.ir, prog[0]);
        run_to(2);
        check("s1_f1", bf.ir, prog[1]);
        check("s1_exv", 32'(bf.ex_valid), 32'd1);
        run_to(3);
        check("s1_f2",   bf.ir, prog[2]);
        check("s1_addr", 32'(bf.imem_addr), 32'd3);
        check("s1_wbv",  32'(bf.wb_valid), 32'd1);

        // Scenario 2 (and 4 for FORWARD=0): ADD R3 ; SUB R4,R3,R1 ; later R8 via WB.
        begin_prog();
        prog[0] = op(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 5'd1, 5'd2);
        prog[1] = op(1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 5'd3, 5'd1);
        prog[2] = op(1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 5'd1, 5'd2);
        prog[3] = op(1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 5'd1, 5'd2);
        prog[4] = op(1'b0, 1'b1, 1'b1, 1'b1, 5'd10, 5'd8, 5'd1);
        go();
        run_to(2);
        check("s2_fwd_a_ex", 32'(bf.fwd_a), 32'(FWD_EX));
        check("s2_fwd_b",    32'(bf.fwd_b), 32'(FWD_RF));
        check("s2_nostall",  32'(bf.stall), 32'd0);
        check("s4_stall_c1", 32'(bs.stall), 32'd1);
        check("s4_fwd_c1",   32'(bs.fwd_a), 32'(FWD_RF));
        run_to(3);
        check("s2_indep",    32'(bf.fwd_a), 32'(FWD_RF));
        check("s4_stall_c2", 32'(bs.stall), 32'd1);
        check("s4_fwd_c2",   32'(bs.fwd_a), 32'(FWD_RF));
        run_to(4);
        check("s4_stall_c3", 32'(bs.stall), 32'd0);
        check("s4_pc_held",  32'(bs.imem_addr), 32'd2);
        run_to(5);
        check("s2_fwd_a_wb", 32'(bf.fwd_a), 32'(FWD_WB));
        check("s2_fwd_b_wb", 32'(bf.fwd_b), 32'(FWD_RF));

        // Scenario 3: LD R5 ; ADD R6,R5,R5 -> one-cycle load-use stall.
        begin_prog();
        prog[0] = op(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 5'd1, 5'd0);
        prog[1] = op(1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 5'd5, 5'd5);
        go();
        run_to(2);
        check("s3_stall",     32'(bf.stall), 32'd1);
        check("s3_fwd_stall", 32'(bf.fwd_a), 32'(FWD_RF));
        run_to(3);
        check("s3_unstall",   32'(bf.stall), 32'd0);
        check("s3_fwd_a",     32'(bf.fwd_a), 32'(FWD_WB));
        check("s3_fwd_b",     32'(bf.fwd_b), 32'(FWD_WB));
        check("s3_bubble",    32'(bf.ex_valid), 32'd0);
        check("s3_pc_held",   32'(bf.imem_addr), 32'd2);
        check("s3_f0_stall",  32'(bs.stall), 32'd1);
        run_to(4);
        check("s3_pc_resume", 32'(bf.imem_addr), 32'd3);
        check("s3_ir",        bf.ir, prog[2]);

        // Scenario 4b: write R0 then read R0 never stalls.
        begin_prog();
        prog[0] = op(1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd1, 5'd2);
        prog[1] = op(1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
        go();
        run_to(2);
        check("s4_r0_stall", 32'(bs.stall), 32'd0);
        check("s4_r0_fwd",   32'(bf.fwd_a), 32'(FWD_RF));
        run_to(3);
        check("s4_r0_addr",  32'(bs.imem_addr), 32'd3);

        // Scenario 5: taken branch at 4 -> 20 while a load-use hazard is pending.
        begin_prog();
        prog[4]  = br_op(14'd20, 1'b1, 1'b1, 5'd7);
        prog[5]  = op(1'b0, 1'b1, 1'b1, 1'b0, 5'd11, 5'd7, 5'd0);
        prog[6]  = op(1'b0, 1'b1, 1'b1, 1'b0, 5'd12, 5'd1, 5'd0);
        prog[20] = op(1'b0, 1'b1, 1'b1, 1'b1, 5'd13, 5'd1, 5'd2);
        go();
        run_to(6);
        check("s5_stall_ovr",   32'(bf.stall), 32'd0);
        check("s5_stall_ovr0",  32'(bs.stall), 32'd0);
        check("s5_pc2",         32'(bf.pc_2), 32'd5);
        run_to(7);
        check("s5_target",      32'(bf.imem_addr), 32'd20);
        check("s5_target0",     32'(bs.imem_addr), 32'd20);
        check("s5_squash_ex",   32'(bf.ex_valid), 32'd0);
        check("s5_br_wb",       {31'd0, bf.wb_valid}, 32'd1);
        run_to(8);
        check("s5_ir20",        bf.ir, prog[20]);
        check("s5_wb_bub1",     32'(bf.wb_valid), 32'd0);
        check("s5_pc1",         32'(bf.pc_1), 32'd21);
        run_to(9);
        check("s5_wb_bub2",     32'(bf.wb_valid), 32'd0);
        run_to(10);
        check("s5_wb20",        {bf.wb_valid, bf.wb_rw, 27'd0, bf.wb_da[2:0]}, {2'b11, 27'd0, 3'd5});

        // Scenario 6: imem_ready low for 3 cycles, then PC wrap.
        begin_prog();
        go();
        run_to(2);
        imem_ready = 1'b0;
        run_to(3);
        check("s6_hold1", 32'(bf.imem_addr), 32'd2);
        check("s6_exv1",  32'(bf.ex_valid), 32'd1);
        run_to(4);
        check("s6_hold2", 32'(bf.imem_addr), 32'd2);
        check("s6_bub1",  32'(bf.ex_valid), 32'd0);
        run_to(5);
        check("s6_hold3", 32'(bf.imem_addr), 32'd2);
        check("s6_bub2",  32'(bf.ex_valid), 32'd0);
        imem_ready = 1'b1;
        run_to(6);
        check("s6_bub3",  32'(bf.ex_valid), 32'd0);
        check("s6_resume", 32'(bf.imem_addr), 32'd3);
        check("s6_ir",    bf.ir, prog[2]);
        run_to(7);
        check("s6_exv2",  32'(bf.ex_valid), 32'd1);

        begin_prog();
        prog[0] = br_op(14'h3FFF, 1'b0, 1'b0, 5'd0);
        go();
        run_to(3);
        check("s6_top",   32'(bf.imem_addr), 32'h3FFF);
        run_to(4);
        check("s6_wrap",  32'(bf.imem_addr), 32'd0);
        check("s6_wrap_pc1", 32'(bf.pc_1), 32'd0);
        check("s6_wrap_ir",  bf.ir, prog[16383]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/risc_pipe_ctrl.md
Name: risc_pipe_ctrl

Overview:
Parametrised pipeline sequencer for the next-generation RISC CPU. It owns the PC, the IF/DOF/EX/WB valid bits and the destination-tracking registers. It detects read-after-write hazards and resolves each one by forwarding (FORWARD=1) or by stalling, flushes the pipe on a taken branch, and throttles fetch with a ready handshake on the instruction memory. The datapath (register file, function unit, muxes, data memory) stays outside and is steered by this block's select and valid outputs.

Parameters:
DATA_W, 32, datapath and IR width
PC_W, 14, instruction address width
REG_AW, 5, register address width; register 0 is hard-wired zero and never creates a hazard
FORWARD, 1, 1 = bypass from EX/WB with a load-use stall only; 0 = stall until the producer has written back

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
imem_addr  out  PC_W  fetch address (current PC)
imem_ready  in  1  instruction word valid this cycle
imem_rdata  in  DATA_W  fetched instruction
ir  out  DATA_W  instruction held in DOF
pc_1  out  PC_W  PC+1 of the DOF instruction
pc_2  out  PC_W  PC+1 of the EX instruction (branch base)
dec_aa, dec_ba  in  REG_AW  source addresses decoded from ir
dec_use_a, dec_use_b  in  1  source actually read (MA/MB not selecting PC/constant)
dec_rw, dec_da  in  1, REG_AW  decoded write enable and destination
dec_load  in  1  decoded MD selects data memory
br_taken  in  1  branch/jump resolved taken in EX
br_target  in  PC_W  target address from the mux_C path
stall  out  1  DOF held this cycle
fwd_a, fwd_b  out  2  00 = regfile, 01 = EX result F_wire, 10 = WB bus_D
ex_valid, wb_valid  out  1  stage holds a real instruction; the datapath gates MW/RW with these
ex_rw, wb_rw, wb_da  out  1, 1, REG_AW  gated write enable and destination to the regfile

Behaviour:
- Reset (asynchronous, any cycle): PC=0; ir=0; pc_1=0; pc_2=0; all valid bits 0; ex_rw=0, wb_rw=0, wb_da=0; stall=0; fwd_a=00, fwd_b=00. The first fetch is at PC 0 in the first clk edge after reset deasserts.
- Stage registers:
  - IF→DOF: ir, pc_1, dof_valid.
  - DOF→EX: ex_valid, ex_rw, ex_da, ex_load, pc_2.
  - EX→WB: wb_valid, wb_rw, wb_da.
  - All write enables are ANDed with the stage's valid bit.
- Fetch:
  - imem_ready=1 and no stall: ir<=imem_rdata, dof_valid<=1, PC<=PC+1 (wraps modulo 2^PC_W).
  - imem_ready=0: dof_valid<=0 (bubble) and PC holds.
- Hazard match: a source in DOF matches a producer if dof_valid & use & (addr != 0) & producer_rw & (addr == producer_da).
- FORWARD=1:
  - EX match with ex_load=0 → fwd=01.
  - Otherwise, WB match → fwd=10.
  - EX has priority over WB because it is the younger producer.
  - EX match with ex_load=1 → stall=1 for one cycle, then WB forwarding resolves it.
- FORWARD=0: any EX or WB match → stall=1; fwd is held at 00. Worst case is a 2-cycle stall.
- During a stall: PC, ir and pc_1 hold; a bubble enters EX (ex_valid<=0); EX→WB advances normally. imem_addr is unchanged.
- br_taken=1 (evaluated only when ex_valid=1):
  - PC<=br_target.
  - dof_valid<=0 and ex_valid<=0, squashing the 2 younger instructions.
  - stall is overridden to 0 that cycle.
  - Branch has priority over stall and over imem_ready.
- Simultaneous events:
  - Branch during an imem_ready=0 cycle: the redirect still takes effect.
  - WB write and DOF read of the same register in the same cycle is covered by fwd=10. The regfile write-through is not relied on.
- Throughput: one instruction per cycle when there are no hazards, no branches and imem_ready is held high.

Decomposition:
- Package risc_pkg: FWD_RF/FWD_EX/FWD_WB encodings, MD encoding of a load, reset PC constant.
- Sub-module risc_hazard_unit: purely combinational match, priority and stall logic, parametrised by REG_AW and FORWARD. All sequential state stays in risc_pipe_ctrl.

Test Plan:
1. Reset mid-run at PC=7 → next cycle all valid bits 0 and imem_addr=0; after release, fetch resumes at 0, 1, 2 with one instruction per cycle.
2. FORWARD=1: ADD R3 then SUB R4,R3,R1 back-to-back → fwd_a=01 and stall=0; with one independent instruction between them → fwd_a=10.
3. FORWARD=1: LD R5 then ADD R6,R5,R5 → stall=1 for exactly 1 cycle, then fwd_a=fwd_b=10; total penalty 1 cycle.
4. FORWARD=0: same pair as scenario 2 → stall for 2 cycles and fwd stays 00; a write to R0 followed by a read of R0 → no stall.
5. Taken branch at PC=4 with target 20 → the instructions from PC 5 and 6 never reach WB (wb_valid=0 for them); the next valid ir holds the word from 20. A concurrent load-use stall is ignored.
6. imem_ready low for 3 cycles → 3 bubbles (ex_valid=0) and PC holds; wrap test: PC=2^PC_W-1 advances to 0.
